// File: rtl/btn_pkg.sv
// Shared types and constants for the button event arbiter.
// Button indices follow the Nexys4 pad set: centre, up, left, right, down.
package btn_pkg;

    localparam int BTN_N     = 5;
    localparam int BTN_IDX_W = 3;

    localparam logic [BTN_IDX_W-1:0] BTN_C = 3'd0;
    localparam logic [BTN_IDX_W-1:0] BTN_U = 3'd1;
    localparam logic [BTN_IDX_W-1:0] BTN_L = 3'd2;
    localparam logic [BTN_IDX_W-1:0] BTN_R = 3'd3;
    localparam logic [BTN_IDX_W-1:0] BTN_D = 3'd4;

    typedef struct packed {
        logic                 rpt;
        logic [BTN_IDX_W-1:0] idx;
    } btn_evt_t;

    // Reduce a sum of two button indices (0..8) modulo BTN_N.
    function automatic logic [BTN_IDX_W-1:0] btn_wrap(input logic [3:0] v);
        return (v >= 4'(BTN_N)) ? 3'(v - 4'(BTN_N)) : v[2:0];
    endfunction

    function automatic logic [BTN_IDX_W-1:0] btn_next(input logic [BTN_IDX_W-1:0] i);
        return (i == BTN_D) ? BTN_C : i + 3'd1;
    endfunction

endpackage

// File: rtl/btn_event_arbiter_if.sv
// Event stream handshake between the arbiter (master) and its consumer (slave).
interface btn_event_arbiter_if;
    import btn_pkg::*;

    logic                 evt_valid;
    logic                 evt_ready;
    logic [BTN_IDX_W-1:0] evt_code;
    logic                 evt_repeat;

    modport master (output evt_valid, output evt_code, output evt_repeat, input evt_ready);
    modport slave  (input evt_valid, input evt_code, input evt_repeat, output evt_ready);

endinterface

// File: rtl/btn_evt_fifo.sv
// DEPTH-entry FIFO of button events with occupancy count; pointers wrap naturally
// because DEPTH is a power of two. Storage is not reset, only pointers and count.
module btn_evt_fifo
    import btn_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  btn_evt_t                 din,
    input  logic                     pop,
    output btn_evt_t                 dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    btn_evt_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Latches debounced button pulses into pending bits and grants them round-robin
// into an event FIFO. Optional auto-repeat is enabled with `define BTN_REPEAT_EN.
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter int          DEPTH         = 4,
    parameter logic [23:0] REPEAT_DELAY  = 24'd10_000_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd2_500_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BTN_N-1:0]        btn_pulse,
`ifdef BTN_REPEAT_EN
    input  logic [BTN_N-1:0]        btn_level,
`endif
    btn_event_arbiter_if.master     evt,
    output logic                    ovf,
    input  logic                    ovf_clr,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    logic [BTN_N-1:0]     pend;
    logic [BTN_N-1:0]     pend_rep;
    logic [BTN_N-1:0]     fire_oh;
    logic [BTN_N-1:0]     live;
    logic [BTN_N-1:0]     inj_oh;
    logic [BTN_IDX_W-1:0] rr_ptr;
    logic [BTN_IDX_W-1:0] gnt_idx;
    logic [BTN_IDX_W-1:0] cand;
    logic                 gnt_vld;
    logic                 fire;
    logic                 pop;
    logic                 drop;
    logic                 full;
    logic                 empty;
    btn_evt_t             push_evt;
    btn_evt_t             head;

    // Lowest offset from rr_ptr wins: scan offsets high to low so the last hit sticks.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = BTN_N - 1; k >= 0; k--) begin
            cand = btn_wrap({1'b0, rr_ptr} + 4'(k));
            if (pend[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign pop      = ~empty & evt.evt_ready;
    assign fire     = gnt_vld & (~full | pop);
    assign fire_oh  = fire ? (5'(1) << gnt_idx) : '0;
    assign live     = pend & ~fire_oh;
    assign drop     = |(btn_pulse & live);
    assign push_evt = '{rpt: pend_rep[gnt_idx], idx: gnt_idx};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= '0;
            rr_ptr <= BTN_C;
            ovf    <= 1'b0;
        end else begin
            pend <= live | btn_pulse | inj_oh;
            if (fire) rr_ptr <= btn_next(gnt_idx);
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

`ifdef BTN_REPEAT_EN
    logic [23:0]          rpt_cnt;
    logic                 rpt_act;
    logic [BTN_IDX_W-1:0] rpt_tgt;
    logic [BTN_IDX_W-1:0] acc_idx;
    logic [BTN_N-1:0]     acc;
    logic                 expire;

    // A press that was not merged into a live pending bit retargets the timer.
    assign acc = btn_pulse & ~live;

    always_comb begin
        acc_idx = '0;
        for (int k = BTN_N - 1; k >= 0; k--) begin
            if (acc[k]) acc_idx = 3'(k);
        end
    end

    assign expire = rpt_act & btn_level[rpt_tgt] & (rpt_cnt == 24'd1);
    assign inj_oh = expire ? (5'(1) << rpt_tgt) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_act  <= 1'b0;
            rpt_tgt  <= '0;
            rpt_cnt  <= '0;
            pend_rep <= '0;
        end else begin
            // Injection into a live bit merges silently; a real press always clears the tag.
            pend_rep <= ((pend_rep & ~fire_oh) | (inj_oh & ~live)) & ~btn_pulse;
            if (|acc) begin
                rpt_act <= 1'b1;
                rpt_tgt <= acc_idx;
                rpt_cnt <= REPEAT_DELAY;
            end else if (rpt_act && !btn_level[rpt_tgt]) begin
                rpt_act <= 1'b0;
            end else if (expire) begin
                rpt_cnt <= REPEAT_PERIOD;
            end else if (rpt_act) begin
                rpt_cnt <= rpt_cnt - 24'd1;
            end
        end
    end
`else
    logic unused_rpt;

    assign inj_oh     = '0;
    assign pend_rep   = '0;
    assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    btn_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fire),
        .din   (push_evt),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign evt.evt_valid  = ~empty;
    assign evt.evt_code   = empty ? '0 : head.idx;
    assign evt.evt_repeat = ~empty & head.rpt;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Randomised bench with a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_btn_event_arbiter;

    localparam int DEPTH = 4;
    localparam int RDLY  = 10;
    localparam int RPER  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_pulse;
    logic       ovf;
    logic       ovf_clr;
    logic [2:0] fifo_count;
`ifdef BTN_REPEAT_EN
    logic [4:0] btn_level;
`endif

    btn_event_arbiter_if evt_if ();

    btn_event_arbiter #(
        .DEPTH         (DEPTH),
        .REPEAT_DELAY  (24'd10),
        .REPEAT_PERIOD (24'd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_pulse  (btn_pulse),
`ifdef BTN_REPEAT_EN
        .btn_level  (btn_level),
`endif
        .evt        (evt_if),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int nchk  = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Reference model: queue entries encode repeat*8 + button index.
    int         mq[$];
    logic [4:0] mpend;
    logic [4:0] mrep;
    logic [4:0] mlive;
    int         mrr;
    bit         movf;
    int         mg;
    bit         mpop;
`ifdef BTN_REPEAT_EN
    bit         ract;
    int         rleft;
    int         rtgt;
    bit         minj;
    int         macc;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mpend = '0;
            mrep  = '0;
            mrr   = 0;
            movf  = 1'b0;
`ifdef BTN_REPEAT_EN
            ract  = 1'b0;
            rleft = 0;
            rtgt  = 0;
`endif
        end else begin
            mpop = (mq.size() != 0) && evt_if.evt_ready;
            mg = -1;
            for (int k = 0; k < 5; k++)
                if (mg < 0 && mpend[(mrr + k) % 5]) mg = (mrr + k) % 5;
            if (!(mq.size() < DEPTH || mpop)) mg = -1;
            if (mpop) void'(mq.pop_front());
            if (mg >= 0) begin
                mq.push_back(int'(mrep[mg]) * 8 + mg);
                mrr = (mg + 1) % 5;
                mpend[mg] = 1'b0;
                mrep[mg]  = 1'b0;
            end
            mlive = mpend;
            if ((btn_pulse & mlive) != 0) movf = 1'b1;
            else if (ovf_clr)             movf = 1'b0;
            mpend = mpend | btn_pulse;
            mrep  = mrep & ~btn_pulse;
`ifdef BTN_REPEAT_EN
            minj = ract && btn_level[rtgt] && (rleft == 1);
            macc = -1;
            for (int k = 4; k >= 0; k--)
                if (btn_pulse[k] && !mlive[k]) macc = k;
            if (minj && !mlive[rtgt] && !btn_pulse[rtgt]) begin
                mpend[rtgt] = 1'b1;
                mrep[rtgt]  = 1'b1;
            end
            if (macc >= 0) begin
                ract = 1'b1; rtgt = macc; rleft = RDLY;
            end else if (ract && !btn_level[rtgt]) ract = 1'b0;
            else if (minj) rleft = RPER;
            else if (ract) rleft--;
`endif
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("cyc_valid",  evt_if.evt_valid,  mq.size() != 0);
            chk("cyc_code",   evt_if.evt_code,   (mq.size() != 0) ? mq[0] % 8 : 0);
            chk("cyc_repeat", evt_if.evt_repeat, (mq.size() != 0) ? mq[0] / 8 : 0);
            chk("cyc_count",  fifo_count,        mq.size());
            chk("cyc_ovf",    ovf,               movf);
        end
    end

    task automatic cyc(input logic [4:0] p, input logic r, input logic c);
        btn_pulse = p;
        evt_if.evt_ready = r;
        ovf_clr = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_pulse = '0;
        evt_if.evt_ready = 1'b0;
        ovf_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drain with ready high, checking the delivered codes against an expected list.
    task automatic drain(input string nm, input int exp_codes[$]);
        int got[$];
        for (int i = 0; i < 12; i++) begin
            if (evt_if.evt_valid) got.push_back(int'(evt_if.evt_code));
            cyc(5'b0, 1'b1, 1'b0);
        end
        chk({nm, "_n"}, got.size(), exp_codes.size());
        for (int i = 0; i < exp_codes.size() && i < got.size(); i++)
            chk($sformatf("%s_%0d", nm, i), got[i], exp_codes[i]);
    endtask

    int         ones;
    logic [4:0] rp;
    int         thr;
`ifdef BTN_REPEAT_EN
    int         rtimes[$];
    int         nreal;
`endif

    initial begin
        rst = 1'b1;
        btn_pulse = '0;
        evt_if.evt_ready = 1'b0;
        ovf_clr = 1'b0;
`ifdef BTN_REPEAT_EN
        btn_level = '0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        chk("rst_valid", evt_if.evt_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf",   ovf, 0);
        chk("rst_code",  evt_if.evt_code, 0);

        // Single press on bit 2.
        cyc(5'b00100, 1'b1, 1'b0);
        chk("single_lat_e0", evt_if.evt_valid, 0);
        cyc(5'b0, 1'b1, 1'b0);
        chk("single_valid", evt_if.evt_valid, 1);
        chk("single_code",  evt_if.evt_code, 2);
        chk("single_rep",   evt_if.evt_repeat, 0);
        cyc(5'b0, 1'b1, 1'b0);
        chk("single_pop_cnt", fifo_count, 0);

        // Simultaneous press from rr_ptr = 0.
        do_reset();
        cyc(5'b10101, 1'b1, 1'b0);
        cyc(5'b0, 1'b1, 1'b0);
        chk("sim_c0", evt_if.evt_code, 0);
        cyc(5'b0, 1'b1, 1'b0);
        chk("sim_c2", evt_if.evt_code, 2);
        cyc(5'b0, 1'b1, 1'b0);
        chk("sim_c4", evt_if.evt_code, 4);
        cyc(5'b0, 1'b1, 1'b0);
        chk("sim_empty", evt_if.evt_valid, 0);
        cyc(5'b10001, 1'b1, 1'b0);
        cyc(5'b0, 1'b1, 1'b0);
        chk("sim2_c0", evt_if.evt_code, 0);
        cyc(5'b0, 1'b1, 1'b0);
        chk("sim2_c4", evt_if.evt_code, 4);

        // Backpressure: full FIFO holds the fifth press in pend.
        do_reset();
        cyc(5'b11111, 1'b0, 1'b0);
        repeat (5) cyc(5'b0, 1'b0, 1'b0);
        chk("bp_count", fifo_count, 4);
        chk("bp_model_pend", int'(mpend), 5'b10000);
        chk("bp_head", evt_if.evt_code, 0);
        drain("bp_order", '{0, 1, 2, 3, 4});
        chk("bp_ovf", ovf, 0);

        // Overflow: second press of a pending button while the FIFO is full.
        do_reset();
        cyc(5'b11101, 1'b0, 1'b0);
        repeat (4) cyc(5'b0, 1'b0, 1'b0);
        chk("ovf_full", fifo_count, 4);
        cyc(5'b00010, 1'b0, 1'b0);
        chk("ovf_first", ovf, 0);
        cyc(5'b00010, 1'b0, 1'b0);
        chk("ovf_set", ovf, 1);
        cyc(5'b00010, 1'b0, 1'b1);
        chk("ovf_set_beats_clr", ovf, 1);
        cyc(5'b0, 1'b0, 1'b1);
        chk("ovf_clr", ovf, 0);
        drain("ovf_order", '{0, 2, 3, 4, 1});

        // Randomised traffic with varying backpressure.
        for (int ph = 0; ph < 5; ph++) begin
            thr = 2 + 2 * ph;
            for (int n = 0; n < 300; n++) begin
                for (int b = 0; b < 5; b++) rp[b] = ($urandom_range(3) == 0);
                cyc(rp, $urandom_range(9) < thr, $urandom_range(19) == 0);
            end
        end

        // Asynchronous reset with queued and pending events.
        do_reset();
        cyc(5'b01111, 1'b0, 1'b0);
        cyc(5'b01000, 1'b0, 1'b0);
        cyc(5'b0, 1'b0, 1'b0);
        cyc(5'b0, 1'b0, 1'b0);
        chk("mid_count", fifo_count, 3);
        chk("mid_ovf", ovf, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", evt_if.evt_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_ovf",   ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(5'b0, 1'b1, 1'b0);
        chk("arst_stays_empty", evt_if.evt_valid, 0);

`ifdef BTN_REPEAT_EN
        // Auto-repeat on bit 3 held for 30 cycles.
        do_reset();
        nreal = 0;
        btn_level = 5'b01000;
        cyc(5'b01000, 1'b1, 1'b0);
        for (int k = 1; k <= 45; k++) begin
            btn_level = (k <= 30) ? 5'b01000 : 5'b0;
            cyc(5'b0, 1'b1, 1'b0);
            if (evt_if.evt_valid) begin
                if (evt_if.evt_repeat) rtimes.push_back(k);
                else begin
                    nreal++;
                    chk("rpt_first_time", k, 1);
                end
                chk("rpt_code", evt_if.evt_code, 3);
            end
        end
        chk("rpt_real_n", nreal, 1);
        chk("rpt_n", rtimes.size(), 6);
        for (int j = 0; j < rtimes.size(); j++) begin
            ones = rtimes[j] - (RDLY + RPER * j);
            chk($sformatf("rpt_time_%0d", j), (ones >= -2 && ones <= 2), 1);
        end
`endif

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
